// File: rtl/inst_imm_encoder_pkg.sv
// Shared immediate-format codes and pipeline stage record for the immediate encoder.
// The format codes must stay identical to the ones the ID-stage SIGN_EXTEND decoder uses.
package inst_imm_encoder_pkg;

  localparam logic [2:0] U_TYPE     = 3'b000;
  localparam logic [2:0] J_TYPE     = 3'b001;
  localparam logic [2:0] I_TYPE     = 3'b010;
  localparam logic [2:0] B_TYPE     = 3'b011;
  localparam logic [2:0] S_TYPE     = 3'b100;
  localparam logic [2:0] SHAMT_TYPE = 3'b101;
  localparam int         UNSIGNED_BIT = 3;

  typedef struct packed {
    logic        v;
    logic        err;
    logic [31:0] inst;
  } stage_t;

  // True when value[31:lsb] is all zeros or all ones, i.e. a valid sign extension.
  function automatic logic all_same(input logic [31:0] value, input int unsigned lsb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << lsb;
    return ((value & mask) == 32'h0) || ((value & mask) == mask);
  endfunction

endpackage

// File: rtl/inst_imm_encoder_if.sv
// Input/output handshake bus of the immediate encoder.
// slave is the encoder's view, master is the view of whoever drives and drains it.
interface inst_imm_encoder_if;

  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] BASE_INST;
  logic [31:0] IMM;
  logic [3:0]  IMM_SEL;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_INST;
  logic        OUT_RANGE_ERR;

  modport slave (
    input  IN_VALID, BASE_INST, IMM, IMM_SEL, OUT_READY,
    output IN_READY, OUT_VALID, OUT_INST, OUT_RANGE_ERR
  );

  modport master (
    output IN_VALID, BASE_INST, IMM, IMM_SEL, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_INST, OUT_RANGE_ERR
  );

endinterface

// File: rtl/inst_imm_encoder_imm_field_pack.sv
// Combinational placement of an immediate into its RV32 instruction fields plus range check.
// Out-of-range immediates are still placed bit-exactly; only err reports the truncation.
module imm_field_pack
  import inst_imm_encoder_pkg::*;
(
  input  logic [31:0] base_inst,
  input  logic [31:0] imm,
  input  logic [3:0]  imm_sel,
  output logic [31:0] word,
  output logic        err
);

  always_comb begin
    word = base_inst;
    err  = 1'b0;
    case (imm_sel[2:0])
      U_TYPE: begin
        word[31:12] = imm[31:12];
        err         = |imm[11:0];
      end
      J_TYPE: begin
        word[31]    = imm[20];
        word[30:21] = imm[10:1];
        word[20]    = imm[11];
        word[19:12] = imm[19:12];
        err         = !all_same(imm, 20) || imm[0];
      end
      I_TYPE: begin
        word[31:20] = imm[11:0];
        err         = imm_sel[UNSIGNED_BIT] ? (|imm[31:12]) : !all_same(imm, 11);
      end
      B_TYPE: begin
        word[31]    = imm[12];
        word[30:25] = imm[10:5];
        word[11:8]  = imm[4:1];
        word[7]     = imm[11];
        err         = !all_same(imm, 12) || imm[0];
      end
      S_TYPE: begin
        word[31:25] = imm[11:5];
        word[11:7]  = imm[4:0];
        err         = !all_same(imm, 11);
      end
      SHAMT_TYPE: begin
        word[24:20] = imm[4:0];
        err         = |imm[31:5];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_imm_encoder.sv
// Two-stage pipelined immediate encoder for the debug/program-load path (inverse of SIGN_EXTEND).
// S1 holds the freshly packed word, S2 is the output register; a saturating counter tracks errors.
module inst_imm_encoder
  import inst_imm_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 FLUSH,
  inst_imm_encoder_if.slave    bus,
  output logic [ERR_CNT_W-1:0] ERR_COUNT
);

  logic [31:0] packed_word;
  logic        packed_err;
  stage_t      s1;
  stage_t      s2;
  logic        s1_adv;
  logic        s2_adv;
  logic        in_fire;
  logic        out_fire;

  imm_field_pack u_pack (
    .base_inst (bus.BASE_INST),
    .imm       (bus.IMM),
    .imm_sel   (bus.IMM_SEL),
    .word      (packed_word),
    .err       (packed_err)
  );

  assign s2_adv       = !s2.v || bus.OUT_READY;
  assign s1_adv       = !s1.v || s2_adv;
  assign bus.IN_READY = s1_adv && !FLUSH;
  assign in_fire      = bus.IN_VALID && bus.IN_READY;
  assign out_fire     = s2.v && bus.OUT_READY;

  // Payloads only load on a real transfer so a stalled output word never changes under the consumer.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1 <= '0;
      s2 <= '0;
    end else if (FLUSH) begin
      s1.v <= 1'b0;
      s2.v <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2.v <= s1.v;
        if (s1.v) begin
          s2.inst <= s1.inst;
          s2.err  <= s1.err;
        end
      end
      if (s1_adv) begin
        s1.v <= in_fire;
        if (in_fire) begin
          s1.inst <= packed_word;
          s1.err  <= packed_err;
        end
      end
    end
  end

  // Counts completed error transfers, including one that completes in a FLUSH cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ERR_COUNT <= '0;
    end else if (out_fire && s2.err && (ERR_COUNT != '1)) begin
      ERR_COUNT <= ERR_COUNT + 1'b1;
    end
  end

  assign bus.OUT_VALID     = s2.v;
  assign bus.OUT_INST      = s2.inst;
  assign bus.OUT_RANGE_ERR = s2.err;

endmodule
